// File: rtl/multicycle_sequencer_if.sv
// multicycle_sequencer_if: control bundle between the multicycle sequencer and its datapath/memory
interface multicycle_sequencer_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] instruction;
  logic             zero;
  logic             mem_ready;
  logic             iord;
  logic             memread;
  logic             memwrite;
  logic             irwrite;
  logic             pcwrite;
  logic             pcsrc;
  logic             alusrc;
  logic [3:0]       aluop;
  logic             memtoreg;
  logic             regwrite;
  logic             instr_done;
  logic             illegal;
  logic             bus_err;
  logic [3:0]       state;
  modport slave (
    input  instruction, zero, mem_ready,
    output iord, memread, memwrite, irwrite, pcwrite, pcsrc, alusrc, aluop,
           memtoreg, regwrite, instr_done, illegal, bus_err, state
  );
  modport master (
    output instruction, zero, mem_ready,
    input  iord, memread, memwrite, irwrite, pcwrite, pcsrc, alusrc, aluop,
           memtoreg, regwrite, instr_done, illegal, bus_err, state
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: RV32 subset multicycle controller sharing one memory port, with illegal/timeout traps
module multicycle_sequencer #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input logic                   clk,
  input logic                   rst,
  multicycle_sequencer_if.slave bus
);
  typedef enum logic [3:0] {
    START  = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    EXEC_R = 4'd3,
    ADDR   = 4'd4,
    MEM_RD = 4'd5,
    MEM_WR = 4'd6,
    WB_R   = 4'd7,
    WB_MEM = 4'd8,
    BRANCH = 4'd9,
    TRAP   = 4'd10,
    BERR   = 4'd11
  } state_t;
  state_t           state, nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] ins;
  logic [6:0]       opcode;
  logic [3:0]       funct;
  logic             r_ok, wait_st, limit, unused_bits;
  assign ins         = bus.instruction;
  assign unused_bits = ^ins;
  assign opcode      = ins[6:0];
  assign funct       = {ins[30], ins[14:12]};
  assign r_ok        = funct inside {4'b1000, 4'b0000, 4'b0110, 4'b0111};
  assign wait_st     = state inside {FETCH, MEM_RD, MEM_WR};
  assign limit       = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));
  assign bus.state   = state;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= START;
      cnt   <= '0;
    end else begin
      state <= nxt;
      cnt   <= (wait_st && !bus.mem_ready && nxt == state) ? cnt + 1'b1 : '0;
    end
  always_comb begin
    nxt            = state;
    bus.iord       = 1'b0;
    bus.memread    = 1'b0;
    bus.memwrite   = 1'b0;
    bus.irwrite    = 1'b0;
    bus.pcwrite    = 1'b0;
    bus.pcsrc      = 1'b0;
    bus.alusrc     = 1'b0;
    bus.aluop      = 4'b1111;
    bus.memtoreg   = 1'b0;
    bus.regwrite   = 1'b0;
    bus.instr_done = 1'b0;
    bus.illegal    = 1'b0;
    bus.bus_err    = 1'b0;
    case (state)
      START: nxt = FETCH;
      FETCH: begin
        bus.memread = 1'b1;
        bus.irwrite = bus.mem_ready;
        bus.pcwrite = bus.mem_ready;
        nxt = bus.mem_ready ? DECODE : limit ? BERR : FETCH;
      end
      DECODE: nxt = opcode == 7'b0110011 ? (r_ok ? EXEC_R : TRAP) :
                    (opcode == 7'b0000011 || opcode == 7'b0100011) ? ADDR :
                    opcode == 7'b1100011 ? BRANCH : TRAP;
      EXEC_R: begin
        bus.aluop = funct == 4'b1000 ? 4'b0110 :
                    funct == 4'b0000 ? 4'b0010 :
                    funct == 4'b0110 ? 4'b0001 : 4'b0000;
        nxt = WB_R;
      end
      WB_R: begin
        bus.regwrite   = 1'b1;
        bus.instr_done = 1'b1;
        nxt = FETCH;
      end
      ADDR: begin
        bus.alusrc = 1'b1;
        bus.aluop  = 4'b0010;
        nxt = ins[5] ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        bus.iord    = 1'b1;
        bus.memread = 1'b1;
        nxt = bus.mem_ready ? WB_MEM : limit ? BERR : MEM_RD;
      end
      MEM_WR: begin
        bus.iord       = 1'b1;
        bus.memwrite   = 1'b1;
        bus.instr_done = bus.mem_ready;
        nxt = bus.mem_ready ? FETCH : limit ? BERR : MEM_WR;
      end
      WB_MEM: begin
        bus.memtoreg   = 1'b1;
        bus.regwrite   = 1'b1;
        bus.instr_done = 1'b1;
        nxt = FETCH;
      end
      BRANCH: begin
        bus.aluop      = 4'b0110;
        bus.instr_done = 1'b1;
        bus.pcwrite    = bus.zero;
        bus.pcsrc      = bus.zero;
        nxt = FETCH;
      end
      TRAP: bus.illegal = 1'b1;
      BERR: bus.bus_err = 1'b1;
      default: nxt = START;
    endcase
  end
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: directed plus randomized instruction streams checked against a per-cycle trace model
module tb_multicycle_sequencer;
  localparam int TIMEOUT = 16;
  localparam logic [11:0] IORD = 12'h800, MRD = 12'h400, MWR = 12'h200, IRW = 12'h100,
                          PCW = 12'h080, PCS = 12'h040, ALS = 12'h020, M2R = 12'h010,
                          RW = 12'h008, DN = 12'h004, ILL = 12'h002, BER = 12'h001;
  localparam logic [3:0] NO = 4'hF;
  typedef struct packed {
    logic [3:0]  st;
    logic [3:0]  aluop;
    logic [11:0] s;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic z = 1'b0;
  int   vec = 0;
  int   miss = 0;
  exp_t eq[$];
  bit   rq[$];
  exp_t obs;
  multicycle_sequencer_if #(.WIDTH(32)) v ();
  multicycle_sequencer #(.WIDTH(32), .TIMEOUT(TIMEOUT), .CNT_W(5)) dut (.clk(clk), .rst(rst), .bus(v.slave));
  always #5 clk = ~clk;
  assign obs = {v.state, v.aluop, v.iord, v.memread, v.memwrite, v.irwrite, v.pcwrite, v.pcsrc,
                v.alusrc, v.memtoreg, v.regwrite, v.instr_done, v.illegal, v.bus_err};
  function automatic exp_t mk(input logic [3:0] st, input logic [3:0] op, input logic [11:0] s);
    return {st, op, s};
  endfunction
  task automatic push(input exp_t e, input bit r);
    eq.push_back(e);
    rq.push_back(r);
  endtask
  task automatic chk(input string tag, input exp_t e);
    vec++;
    assert (obs === e) else begin
      miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask
  task automatic add_fetch(input int wf);
    for (int i = 0; i < wf; i++) push(mk(1, NO, MRD), 1'b0);
    push(mk(1, NO, MRD | IRW | PCW), 1'b1);
  endtask
  task automatic add_body(input logic [31:0] ins, input int wm, output bit ill);
    logic [3:0] f;
    f = {ins[30], ins[14:12]};
    ill = 1'b0;
    push(mk(2, NO, 0), 1'($urandom));
    if (ins[6:0] == 7'h33 && f inside {4'b1000, 4'b0000, 4'b0110, 4'b0111}) begin
      push(mk(3, f == 4'b1000 ? 4'b0110 : f == 4'b0000 ? 4'b0010 : f == 4'b0110 ? 4'b0001 : 4'b0000, 0), 1'($urandom));
      push(mk(7, NO, RW | DN), 1'($urandom));
    end else if (ins[6:0] == 7'h03) begin
      push(mk(4, 4'b0010, ALS), 1'($urandom));
      for (int i = 0; i < wm; i++) push(mk(5, NO, IORD | MRD), 1'b0);
      push(mk(5, NO, IORD | MRD), 1'b1);
      push(mk(8, NO, M2R | RW | DN), 1'($urandom));
    end else if (ins[6:0] == 7'h23) begin
      push(mk(4, 4'b0010, ALS), 1'($urandom));
      for (int i = 0; i < wm; i++) push(mk(6, NO, IORD | MWR), 1'b0);
      push(mk(6, NO, IORD | MWR | DN), 1'b1);
    end else if (ins[6:0] == 7'h63) begin
      push(mk(9, 4'b0110, DN | (z ? (PCW | PCS) : 12'h0)), 1'($urandom));
    end else begin
      ill = 1'b1;
      for (int i = 0; i < 10; i++) push(mk(10, NO, ILL), 1'($urandom));
    end
  endtask
  task automatic run(input int exp_lat);
    int  f0;
    bit  seen;
    f0 = -1;
    seen = 1'b0;
    for (int i = 0; i < eq.size(); i++) begin
      if (f0 < 0 && eq[i].st == 4'd1) f0 = i;
      @(negedge clk);
      v.mem_ready = rq[i];
      v.zero = z;
      #1;
      chk($sformatf("cycle%0d_state%0d", i, eq[i].st), eq[i]);
      if (exp_lat > 0 && !seen && obs.s[2] === 1'b1) begin
        seen = 1'b1;
        vec++;
        assert (i - f0 + 1 == exp_lat) else begin
          miss++;
          $error("FAIL latency observed=%0d expected=%0d", i - f0 + 1, exp_lat);
        end
      end
    end
    if (exp_lat > 0 && !seen) begin
      miss++;
      $error("FAIL latency observed=no_done expected=%0d", exp_lat);
    end
    eq.delete();
    rq.delete();
  endtask
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("reset", mk(0, NO, 0));
    @(posedge clk);
    #2;
    rst = 1'b0;
    push(mk(0, NO, 0), 1'($urandom));
  endtask
  task automatic one(input logic [31:0] ins, input int wf, input int wm, input bit zz);
    bit ill;
    int lat;
    z = zz;
    v.instruction = ins;
    lat = ins[6:0] == 7'h03 ? 5 + wm : ins[6:0] == 7'h23 ? 4 + wm : ins[6:0] == 7'h63 ? 3 : 4;
    add_fetch(wf);
    add_body(ins, wm, ill);
    run(ill ? 0 : lat + wf);
    if (ill) do_reset();
  endtask
  initial begin
    logic [31:0] ins;
    logic [3:0]  f;
    v.instruction = '0;
    v.mem_ready = 1'b0;
    v.zero = 1'b0;
    do_reset();
    one(32'h002081B3, 0, 0, 1'b0);
    one(32'h00802283, 0, 3, 1'b0);
    one(32'h00000063, 0, 0, 1'b1);
    one(32'h00000063, 0, 0, 1'b0);
    one(32'h00000013, 0, 0, 1'b0);
    one(32'h402091B3, 0, 0, 1'b0);
    one(32'h0020E1B3, 1, 0, 1'b0);
    one(32'h0020F1B3, 0, 0, 1'b0);
    one(32'h402081B3, 2, 0, 1'b0);
    one(32'h0020E1B3, 0, 0, 1'b0);
    one(32'h0020F1B3, 0, 0, 1'b0);
    one(32'h0020A423, 2, 3, 1'b0);
    run(0);
    for (int i = 0; i < TIMEOUT; i++) push(mk(1, NO, MRD), 1'b0);
    for (int i = 0; i < 5; i++) push(mk(11, NO, BER), 1'($urandom));
    run(0);
    do_reset();
    one(32'h002081B3, TIMEOUT - 1, 0, 1'b0);
    for (int n = 0; n < 40; n++) begin
      ins = $urandom;
      case ($urandom_range(0, 4))
        0: begin
          f = 4'(($urandom_range(0, 3) == 0) ? 4'b1000 : ($urandom_range(0, 2) == 0) ? 4'b0000 : ($urandom_range(0, 1) == 0) ? 4'b0110 : 4'b0111);
          {ins[30], ins[14:12], ins[6:0]} = {f, 7'h33};
        end
        1: ins[6:0] = 7'h03;
        2: ins[6:0] = 7'h23;
        3: ins[6:0] = 7'h63;
        default: begin
          if ($urandom_range(0, 1) == 0) begin
            f = 4'($urandom);
            while (f inside {4'b1000, 4'b0000, 4'b0110, 4'b0111}) f = 4'($urandom);
            {ins[30], ins[14:12], ins[6:0]} = {f, 7'h33};
          end else
            while (ins[6:0] inside {7'h33, 7'h03, 7'h23, 7'h63}) ins[6:0] = 7'($urandom);
        end
      endcase
      one(ins, $urandom_range(0, 3), $urandom_range(0, 4), 1'($urandom));
    end
    v.instruction = 32'h0020A423;
    add_fetch(0);
    push(mk(2, NO, 0), 1'b1);
    push(mk(4, 4'b0010, ALS), 1'b1);
    push(mk(6, NO, IORD | MWR), 1'b0);
    push(mk(6, NO, IORD | MWR), 1'b0);
    run(0);
    do_reset();
    push(mk(1, NO, MRD | IRW | PCW), 1'b1);
    run(0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multicycle controller for the RV32 subset datapath: add, sub, or, and, lw, sw, beq.
- Sequences fetch/decode/execute/memory/writeback over several cycles through one shared memory port, and waits on the memory ready handshake.
- Replaces the single-cycle decode when the core runs with one unified instruction/data memory.
- Detects illegal instructions and memory timeouts; both are sticky until reset.

Parameters:
- WIDTH, 32, instruction width; decode uses bits [30], [14:12], [6:0].
- TIMEOUT, 16, consecutive MEM_READY-low cycles in a memory state before bus error; 0 disables the timeout.
- CNT_W, 5, width of the wait counter; must hold TIMEOUT.

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous reset, active-high
- INSTRUCTION  in  WIDTH  instruction register contents, stable from DECODE onward
- ZERO  in  1  ALU zero flag
- MEM_READY  in  1  memory completes the current read/write this cycle
- IORD  out  1  memory address select: 0=PC, 1=ALU result register
- MEMREAD  out  1  memory read request
- MEMWRITE  out  1  memory write request
- IRWRITE  out  1  load IR and OLDPC
- PCWRITE  out  1  PC write enable
- PCSRC  out  1  PC source: 0=PC+4, 1=OLDPC+imm
- ALUSRC  out  1  ALU B operand: 0=rs2, 1=immediate
- ALUOP  out  4  0000 and, 0001 or, 0010 add, 0110 sub, 1111 none
- MEMTOREG  out  1  writeback source: 1=memory data register, 0=ALU result register
- REGWRITE  out  1  register file write enable
- INSTR_DONE  out  1  one-cycle pulse in the last cycle of each retired instruction
- ILLEGAL  out  1  high in TRAP state
- BUS_ERR  out  1  high in BERR state
- STATE  out  4  current state encoding, for debug

Behaviour:
- State register and wait counter are reset asynchronously by RST; state goes to START.
- Outputs are decoded combinationally from state, INSTRUCTION, ZERO and MEM_READY.
- Every output not listed for a state is 0; ALUOP defaults to 1111.
- Reset values: all outputs 0 except ALUOP=1111 and STATE=START encoding.
- State encodings:
  - START=0, FETCH=1, DECODE=2, EXEC_R=3, ADDR=4, MEM_RD=5, MEM_WR=6
  - WB_R=7, WB_MEM=8, BRANCH=9, TRAP=10, BERR=11
- START: no strobes; next state FETCH.
- FETCH: IORD=0, MEMREAD=1.
  - MEM_READY=1: IRWRITE=1, PCWRITE=1, PCSRC=0, next DECODE.
  - MEM_READY=0: stay in FETCH.
- DECODE: no strobes. Next state by INSTRUCTION[6:0]:
  - 0110011 -> EXEC_R, if {INSTRUCTION[30],INSTRUCTION[14:12]} is 1000, 0000, 0110 or 0111; otherwise TRAP.
  - 0000011 or 0100011 -> ADDR
  - 1100011 -> BRANCH
  - any other opcode -> TRAP
- EXEC_R: ALUSRC=0; ALUOP: 1000->0110, 0000->0010, 0110->0001, 0111->0000; next WB_R.
- WB_R: MEMTOREG=0, REGWRITE=1, INSTR_DONE=1; next FETCH.
- ADDR: ALUSRC=1, ALUOP=0010; next MEM_RD for lw, MEM_WR for sw.
- MEM_RD: IORD=1, MEMREAD=1; MEM_READY=1 -> WB_MEM, else stay.
- MEM_WR: IORD=1, MEMWRITE=1.
  - MEM_READY=1: INSTR_DONE=1, next FETCH.
  - MEM_READY=0: stay.
- WB_MEM: MEMTOREG=1, REGWRITE=1, INSTR_DONE=1; next FETCH.
- BRANCH: ALUSRC=0, ALUOP=0110, INSTR_DONE=1.
  - PCWRITE=ZERO, PCSRC=1 when ZERO=1.
  - Next FETCH.
- TRAP: ILLEGAL=1, all strobes 0; stays until RST.
- BERR: BUS_ERR=1, all strobes 0; stays until RST.
- Latency with MEM_READY always high:
  - beq: 3 cycles
  - R-type: 4 cycles
  - sw: 4 cycles
  - lw: 5 cycles
- Each cycle MEM_READY is low in FETCH/MEM_RD/MEM_WR adds one cycle.
- Wait counter:
  - Cleared on every entry to FETCH, MEM_RD or MEM_WR, and whenever MEM_READY=1.
  - Increments on each cycle in those states with MEM_READY=0.
  - When the count reaches TIMEOUT-1 and MEM_READY=0 (TIMEOUT>0), next state is BERR; TIMEOUT consecutive waiting cycles therefore trigger BERR.
  - MEM_READY=1 in the same cycle as the limit wins: normal transition.
- Memory request stability: MEMREAD/MEMWRITE/IORD hold constant while waiting and drop the cycle after MEM_READY.
- REGWRITE and MEMWRITE are never both 1. PCWRITE is only asserted in FETCH and BRANCH.
- RST asserted mid-instruction: the next state is START immediately and asynchronously, and all strobes drop without waiting for a clock. A pending memory request is abandoned.

Test Plan:
- Reset, then add x3,x1,x2 (0x002081B3), MEM_READY=1 -> states 0,1,2,3,7,1; EXEC_R ALUOP=0010; WB_R REGWRITE=1 and INSTR_DONE=1; exactly one PCWRITE in FETCH.
- lw x5,8(x0) (0x00802283), with MEM_READY low for 3 cycles in MEM_RD -> MEM_RD lasts 4 cycles with MEMREAD=1, IORD=1 held; WB_MEM MEMTOREG=1; total 8 cycles.
- beq with ZERO=1, then ZERO=0 -> BRANCH PCWRITE=1 and PCSRC=1, then PCWRITE=0; ALUOP=0110 in both; 3 cycles each.
- Opcode 0x00000013 (addi), and sub/or/and variants with funct3=001 -> TRAP; ILLEGAL=1 held 10 cycles with all strobes 0; RST clears it.
- TIMEOUT=16, MEM_READY stuck low in FETCH -> BERR entered after 16 waiting cycles, BUS_ERR=1; a retry with MEM_READY rising at the 16th cycle (count=15) -> normal DECODE.
- RST pulsed mid-MEM_WR -> MEMWRITE drops asynchronously; after release START then FETCH; no INSTR_DONE for the aborted sw.
